// File: rtl/intpol2_D4_pkg.sv
// Shared types and constants for the quadratic interpolator control block.
package intpol2_D4_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_LOAD2,
    ST_COEF,
    ST_MUL1,
    ST_MUL2,
    ST_OUT,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam logic [1:0] XI2_HOLD  = 2'b00;
  localparam logic [1:0] XI2_FIRST = 2'b01;
  localparam logic [1:0] XI2_STEP  = 2'b10;

endpackage

// File: rtl/intpol2_D4_step_cnt.sv
// Per-segment step counter: latches the point count (0 read as 1) and tracks
// the current step index with first/last flags.
module intpol2_D4_step_cnt #(
  parameter int unsigned CNT_WIDTH = intpol2_D4_pkg::CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_n,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic                 o_is_first,
  output logic                 o_is_last
);

  logic [CNT_WIDTH-1:0] r_n;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_n_m1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_n   <= CNT_WIDTH'(1);
      r_cnt <= '0;
    end else if (i_load) begin
      r_n   <= (i_n == '0) ? CNT_WIDTH'(1) : i_n;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_n_m1     = r_n - CNT_WIDTH'(1);
  assign o_is_first = (r_cnt == '0);
  assign o_is_last  = (r_cnt == w_n_m1);

endmodule

// File: rtl/intpol2_d4_ctrl.sv
// Control FSM for the quadratic interpolator datapath.
// Optional feature: INTPOL2_D4_FLUSH_EN (i_last ends the run via DONE).
module intpol2_d4_ctrl #(
  parameter int unsigned CNT_WIDTH = intpol2_D4_pkg::CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] n_steps,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 clear,
  output logic                 Ld_M0,
  output logic                 Ld_M1,
  output logic                 Ld_M2,
  output logic                 en_stream,
  output logic                 op_1,
  output logic                 en_sum,
  output logic                 Ld_p1_xi,
  output logic                 Ld_data,
  output logic                 sel_mult,
  output logic [1:0]           sel_xi2,
  output logic                 busy,
  output logic                 done
);

  import intpol2_D4_pkg::*;

  state_t r_state;
  state_t w_next;

  logic w_cnt_load;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_is_first;
  logic w_is_last;
  logic w_in_hs;
  logic w_flush;

  intpol2_D4_step_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_step_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_cnt_load),
    .i_n        (n_steps),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .o_is_first (w_is_first),
    .o_is_last  (w_is_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  assign busy    = (r_state != ST_IDLE);
  assign w_in_hs = i_ready & i_valid;

`ifdef INTPOL2_D4_FLUSH_EN
  logic r_last_seen;

  // Sticky across segments; only a return to IDLE forgets it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       r_last_seen <= 1'b0;
    else if (r_state == ST_IDLE)     r_last_seen <= 1'b0;
    else if (w_in_hs && i_last)      r_last_seen <= 1'b1;
  end

  assign w_flush = r_last_seen;
`else
  logic w_unused_last;

  assign w_unused_last = i_last;
  assign w_flush       = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    i_ready    = 1'b0;
    o_valid    = 1'b0;
    clear      = 1'b0;
    Ld_M0      = 1'b0;
    Ld_M1      = 1'b0;
    Ld_M2      = 1'b0;
    en_stream  = 1'b0;
    op_1       = 1'b0;
    en_sum     = 1'b0;
    Ld_p1_xi   = 1'b0;
    Ld_data    = 1'b0;
    sel_mult   = 1'b0;
    sel_xi2    = XI2_HOLD;
    done       = 1'b0;

    // Abort masks every strobe and handshake in its own cycle.
    if (abort) begin
      w_next    = ST_IDLE;
      w_cnt_clr = 1'b1;
`ifndef INTPOL2_D4_FLUSH_EN
      done      = busy;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            clear      = 1'b1;
            w_cnt_load = 1'b1;
            w_next     = ST_LOAD0;
          end
        end
        ST_LOAD0: begin
          i_ready = 1'b1;
          if (i_valid) begin
            Ld_M0  = 1'b1;
            w_next = ST_LOAD1;
          end
        end
        ST_LOAD1: begin
          i_ready = 1'b1;
          if (i_valid) begin
            Ld_M1  = 1'b1;
            w_next = ST_LOAD2;
          end
        end
        ST_LOAD2: begin
          i_ready = 1'b1;
          if (i_valid) begin
            Ld_M2  = 1'b1;
            w_next = ST_COEF;
          end
        end
        ST_COEF: begin
          op_1   = 1'b1;
          w_next = ST_MUL1;
        end
        ST_MUL1: begin
          Ld_p1_xi = 1'b1;
          w_next   = ST_MUL2;
        end
        ST_MUL2: begin
          sel_mult = 1'b1;
          Ld_data  = 1'b1;
          w_next   = ST_OUT;
        end
        ST_OUT: begin
          o_valid = 1'b1;
          if (o_ready) begin
            if (!w_is_last) begin
              en_sum    = 1'b1;
              sel_xi2   = w_is_first ? XI2_FIRST : XI2_STEP;
              w_cnt_inc = 1'b1;
              w_next    = ST_MUL1;
            end else begin
              w_next = w_flush ? ST_DONE : ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          i_ready = 1'b1;
          if (i_valid) begin
            en_stream = 1'b1;
            clear     = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = ST_COEF;
          end
        end
        ST_DONE: begin
          done   = 1'b1;
          w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// Directed self-checking bench for intpol2_d4_ctrl (both INTPOL2_D4_FLUSH_EN builds).
module tb_intpol2_d4_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [7:0] n_steps;
  logic       i_valid;
  logic       i_ready;
  logic       i_last;
  logic       o_valid;
  logic       o_ready;
  logic       clear, Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, en_sum;
  logic       Ld_p1_xi, Ld_data, sel_mult, busy, done;
  logic [1:0] sel_xi2;
  logic [15:0] w_obs;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  localparam logic [15:0] CLR  = 16'h8000;
  localparam logic [15:0] M0   = 16'h4000;
  localparam logic [15:0] M1   = 16'h2000;
  localparam logic [15:0] M2   = 16'h1000;
  localparam logic [15:0] ENS  = 16'h0800;
  localparam logic [15:0] OP1  = 16'h0400;
  localparam logic [15:0] ESUM = 16'h0200;
  localparam logic [15:0] P1XI = 16'h0100;
  localparam logic [15:0] LDD  = 16'h0080;
  localparam logic [15:0] SEL  = 16'h0040;
  localparam logic [15:0] XI2  = 16'h0020;
  localparam logic [15:0] XI1  = 16'h0010;
  localparam logic [15:0] RDY  = 16'h0008;
  localparam logic [15:0] OV   = 16'h0004;
  localparam logic [15:0] BSY  = 16'h0002;
  localparam logic [15:0] DN   = 16'h0001;
`ifdef INTPOL2_D4_FLUSH_EN
  localparam logic [15:0] ABORT_EXP = BSY;
`else
  localparam logic [15:0] ABORT_EXP = BSY | DN;
`endif

  always #5 clk = ~clk;

  intpol2_d4_ctrl #(
    .CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .n_steps   (n_steps),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .clear     (clear),
    .Ld_M0     (Ld_M0),
    .Ld_M1     (Ld_M1),
    .Ld_M2     (Ld_M2),
    .en_stream (en_stream),
    .op_1      (op_1),
    .en_sum    (en_sum),
    .Ld_p1_xi  (Ld_p1_xi),
    .Ld_data   (Ld_data),
    .sel_mult  (sel_mult),
    .sel_xi2   (sel_xi2),
    .busy      (busy),
    .done      (done)
  );

  assign w_obs = {clear, Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, en_sum, Ld_p1_xi,
                  Ld_data, sel_mult, sel_xi2, i_ready, o_valid, busy, done};

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %04h want %04h", tag, act, exp);
    end
  endtask

  // Inputs are already set; check mid-cycle, then move to just after the next edge.
  task automatic step_chk(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, w_obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic load3(input string tag);
    i_valid = 1'b1;
    step_chk({tag, "_ld0"}, RDY | M0 | BSY);
    step_chk({tag, "_ld1"}, RDY | M1 | BSY);
    step_chk({tag, "_ld2"}, RDY | M2 | BSY);
    i_valid = 1'b0;
  endtask

  // One segment with o_ready held high: COEF then n x (MUL1, MUL2, OUT).
  task automatic seg(input string tag, input int unsigned n);
    logic [15:0] e_out;
    step_chk({tag, "_coef"}, OP1 | BSY);
    for (int unsigned k = 0; k < n; k++) begin
      step_chk({tag, "_mul1"}, P1XI | BSY);
      step_chk({tag, "_mul2"}, SEL | LDD | BSY);
      e_out = OV | BSY;
      if (k + 1 < n) e_out = e_out | ESUM | ((k == 0) ? XI1 : XI2);
      step_chk({tag, "_out"}, e_out);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; n_steps = '0;
    i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", w_obs, 16'h0000);
    @(posedge clk);
    #1 rstn = 1'b1;

    // n_steps=4 main flow; n_steps changed after start must not matter
    start = 1'b1; n_steps = 8'd4;
    step_chk("t1_start", CLR);
    start = 1'b0; n_steps = 8'd0;
    step_chk("t1_ld0_wait", RDY | BSY);
    load3("t1");
    o_ready = 1'b1;
    seg("t1", 4);
    step_chk("t1_stream_wait", RDY | BSY);

    // back-pressure in OUT
    i_valid = 1'b1; o_ready = 1'b0;
    step_chk("t2_stream", RDY | ENS | CLR | BSY);
    i_valid = 1'b0;
    step_chk("t2_coef", OP1 | BSY);
    step_chk("t2_mul1", P1XI | BSY);
    step_chk("t2_mul2", SEL | LDD | BSY);
    repeat (5) step_chk("t2_hold", OV | BSY);
    o_ready = 1'b1;
    step_chk("t2_release", OV | BSY | ESUM | XI1);
    step_chk("t2_next_mul1", P1XI | BSY);
    abort = 1'b1;
    step_chk("t2_abort", ABORT_EXP);
    abort = 1'b0;
    step_chk("t2_idle", 16'h0000);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1; n_steps = 8'd2;
    step_chk("t3_both", 16'h0000);
    start = 1'b0; abort = 1'b0;
    step_chk("t3_still_idle", 16'h0000);

    // n_steps=0 behaves as 1; start held while busy is ignored
    start = 1'b1; n_steps = 8'd0;
    step_chk("t4_start", CLR);
    start = 1'b0;
    load3("t4");
    start = 1'b1;
    seg("t4a", 1);
    start = 1'b0;
    i_valid = 1'b1;
    step_chk("t4_stream", RDY | ENS | CLR | BSY);
    i_valid = 1'b0;
    seg("t4b", 1);
    i_valid = 1'b1; abort = 1'b1;
    step_chk("t4_abort_stream", ABORT_EXP);
    abort = 1'b0;
    step_chk("t4_after_abort", 16'h0000);
    i_valid = 1'b0;

    // asynchronous reset while holding a point in OUT
    start = 1'b1; n_steps = 8'd3;
    step_chk("t5_start", CLR);
    start = 1'b0;
    load3("t5");
    o_ready = 1'b0;
    step_chk("t5_coef", OP1 | BSY);
    step_chk("t5_mul1", P1XI | BSY);
    step_chk("t5_mul2", SEL | LDD | BSY);
    @(negedge clk);
    chk("t5_out", w_obs, OV | BSY);
    #2 rstn = 1'b0;
    #1 chk("t5_async_rst", w_obs, 16'h0000);
    @(posedge clk);
    #1 rstn = 1'b1;
    o_ready = 1'b1;
    start = 1'b1; n_steps = 8'd1;
    step_chk("t5_restart", CLR);
    start = 1'b0;
    step_chk("t5_ld0_wait", RDY | BSY);
    abort = 1'b1;
    step_chk("t5_abort", ABORT_EXP);
    abort = 1'b0;

    // i_last on the 5th sample, n_steps=2
    start = 1'b1; n_steps = 8'd2;
    step_chk("t6_start", CLR);
    start = 1'b0;
    load3("t6");
    seg("t6a", 2);
    i_valid = 1'b1;
    step_chk("t6_stream4", RDY | ENS | CLR | BSY);
    i_valid = 1'b0;
    seg("t6b", 2);
    i_valid = 1'b1; i_last = 1'b1;
    step_chk("t6_stream5", RDY | ENS | CLR | BSY);
    i_valid = 1'b0; i_last = 1'b0;
    seg("t6c", 2);
`ifdef INTPOL2_D4_FLUSH_EN
    step_chk("t6_done", BSY | DN);
    step_chk("t6_idle", 16'h0000);
`else
    step_chk("t6_no_flush", RDY | BSY);
    abort = 1'b1;
    step_chk("t6_abort", ABORT_EXP);
    abort = 1'b0;
    step_chk("t6_idle", 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
